mem_ctrl_arb: RTL and testbench

Parametrised, multi-channel successor to the single-requester memory controller. It arbitrates NCH independent requesters, such as instruction fetch and load/store, onto one memory port using round-robin priority. Each accepted request is registered and issued as a one-cycle MEM_exec pulse. Read data and per-channel completion are returned, with an optional watchdog timeout.

---
 rtl/mem_ctrl_arb.sv | 143 ++++++++++++++
 tb/tb_mem_ctrl_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_arb.sv
// Round-robin arbiter plus controller multiplexing NCH requesters onto one memory port.
// Define MEM_CTRL_TIMEOUT_EN to enable the wait-state watchdog (TIMEOUT cycles, pulses O_error).
module mem_ctrl_arb #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int SIZE_W  = 2,
   parameter int NCH     = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                  I_clk,
   input  logic                  I_reset,
   input  logic [NCH-1:0]        I_exec,
   input  logic [NCH-1:0]        I_write,
   input  logic [NCH*SIZE_W-1:0] I_size,
   input  logic [NCH*ADDR_W-1:0] I_addr,
   input  logic [NCH*DATA_W-1:0] I_data,
   output logic [NCH-1:0]        O_ready,
   output logic [NCH-1:0]        O_accept,
   output logic [DATA_W-1:0]     O_data,
   output logic [NCH-1:0]        O_data_ready,
   output logic [NCH-1:0]        O_wr_done,
   output logic [NCH-1:0]        O_error,
   input  logic                  MEM_ready,
   output logic                  MEM_exec,
   output logic                  MEM_write,
   output logic [ADDR_W-1:0]     MEM_addr,
   output logic [SIZE_W-1:0]     MEM_size,
   output logic [DATA_W-1:0]     MEM_data_out,
   input  logic [DATA_W-1:0]     MEM_data_in,
   input  logic                  MEM_data_ready
);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   state_t            state;
   logic [PW-1:0]     rr, gnt, cur;
   logic              gnt_vld;
   logic              done;
   logic [SIZE_W-1:0] size_ch [NCH];
   logic [ADDR_W-1:0] addr_ch [NCH];
   logic [DATA_W-1:0] data_ch [NCH];

   if (NCH < 1 || NCH > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mem_ctrl_arb: NCH must be 1..8 and TIMEOUT >= 1");
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign size_ch[i] = I_size[i*SIZE_W +: SIZE_W];
      assign addr_ch[i] = I_addr[i*ADDR_W +: ADDR_W];
      assign data_ch[i] = I_data[i*DATA_W +: DATA_W];
   end

   assign O_ready = {NCH{(state == IDLE) && MEM_ready}};
   assign done    = (state == RD_WAIT) ? MEM_data_ready : MEM_ready;

   // Scan downward so the channel closest above rr is the last (winning) assignment.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         logic [PW-1:0] idx;
         idx = PW'((int'(rr) + k) % NCH);
         if (I_exec[idx]) begin
            gnt_vld = 1'b1;
            gnt     = idx;
         end
      end
   end

`ifdef MEM_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wcnt;
`else
   assign O_error = '0;
`endif

   always_ff @(posedge I_clk) begin
      if (!I_reset) begin
         state        <= IDLE;
         rr           <= '0;
         cur          <= '0;
         MEM_exec     <= 1'b0;
         MEM_write    <= 1'b0;
         MEM_addr     <= '0;
         MEM_size     <= '0;
         MEM_data_out <= '0;
         O_data       <= '0;
         O_accept     <= '0;
         O_data_ready <= '0;
         O_wr_done    <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
         O_error      <= '0;
         wcnt         <= '0;
`endif
      end else begin
         MEM_exec     <= 1'b0;
         O_accept     <= '0;
         O_data_ready <= '0;
         O_wr_done    <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
         O_error      <= '0;
`endif
         case (state)
            IDLE: if (MEM_ready && gnt_vld) begin
               MEM_exec      <= 1'b1;
               O_accept[gnt] <= 1'b1;
               MEM_write     <= I_write[gnt];
               MEM_size      <= size_ch[gnt];
               MEM_addr      <= addr_ch[gnt];
               MEM_data_out  <= data_ch[gnt];
               cur           <= gnt;
               rr            <= (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
               state         <= I_write[gnt] ? WR_WAIT : RD_WAIT;
`ifdef MEM_CTRL_TIMEOUT_EN
               wcnt          <= '0;
`endif
            end
            RD_WAIT, WR_WAIT: if (!MEM_exec) begin
               // Completion is checked before the watchdog so it wins a same-cycle tie.
               if (done) begin
                  if (state == RD_WAIT) begin
                     O_data            <= MEM_data_in;
                     O_data_ready[cur] <= 1'b1;
                  end else begin
                     O_wr_done[cur]    <= 1'b1;
                  end
                  state <= IDLE;
               end
`ifdef MEM_CTRL_TIMEOUT_EN
               else if (wcnt == CW'(TIMEOUT - 1)) begin
                  O_error[cur] <= 1'b1;
                  state        <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Randomized bench for mem_ctrl_arb: reactive memory model feeds a scoreboard queue,
// an independent monitor checks every cycle against a round-robin reference model.
module tb_mem_ctrl_arb;
   localparam int ADDR_W = 16, DATA_W = 16, SIZE_W = 2, NCH = 3, TIMEOUT = 8;

   logic                  I_clk = 1'b0;
   logic                  I_reset;
   logic [NCH-1:0]        I_exec, I_write;
   logic [NCH*SIZE_W-1:0] I_size;
   logic [NCH*ADDR_W-1:0] I_addr;
   logic [NCH*DATA_W-1:0] I_data;
   logic [NCH-1:0]        O_ready, O_accept, O_data_ready, O_wr_done, O_error;
   logic [DATA_W-1:0]     O_data;
   logic                  MEM_ready, MEM_exec, MEM_write, MEM_data_ready;
   logic [ADDR_W-1:0]     MEM_addr;
   logic [SIZE_W-1:0]     MEM_size;
   logic [DATA_W-1:0]     MEM_data_out, MEM_data_in;

   mem_ctrl_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
      .I_clk(I_clk), .I_reset(I_reset), .I_exec(I_exec), .I_write(I_write), .I_size(I_size),
      .I_addr(I_addr), .I_data(I_data), .O_ready(O_ready), .O_accept(O_accept), .O_data(O_data),
      .O_data_ready(O_data_ready), .O_wr_done(O_wr_done), .O_error(O_error),
      .MEM_ready(MEM_ready), .MEM_exec(MEM_exec), .MEM_write(MEM_write), .MEM_addr(MEM_addr),
      .MEM_size(MEM_size), .MEM_data_out(MEM_data_out), .MEM_data_in(MEM_data_in),
      .MEM_data_ready(MEM_data_ready));

   always #5 I_clk = ~I_clk;

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // requester + memory environment state
   logic              req_on [NCH];
   logic              r_wr   [NCH];
   logic [SIZE_W-1:0] r_size [NCH];
   logic [ADDR_W-1:0] r_addr [NCH];
   logic [DATA_W-1:0] r_data [NCH];
   bit                always_req, force_rd, noans, stop_req;
   int                mstate, mcnt;
   logic [DATA_W-1:0] q[$];

   task automatic drive();
      for (int c = 0; c < NCH; c++) begin
         I_exec[c]                    = req_on[c];
         I_write[c]                   = r_wr[c];
         I_size[c*SIZE_W +: SIZE_W]   = r_size[c];
         I_addr[c*ADDR_W +: ADDR_W]   = r_addr[c];
         I_data[c*DATA_W +: DATA_W]   = r_data[c];
      end
   endtask

   // called at each negedge: update requesters, then react as the memory
   task automatic step();
      logic [DATA_W-1:0] d;
      for (int c = 0; c < NCH; c++) begin
         if (req_on[c] && O_accept[c]) req_on[c] = 1'b0;
         if (!req_on[c] && !stop_req && (always_req || $urandom_range(0, 2) == 0)) begin
            req_on[c] = 1'b1;
            r_wr[c]   = force_rd ? 1'b0 : 1'($urandom_range(0, 1));
            r_size[c] = SIZE_W'($urandom);
            r_addr[c] = ADDR_W'($urandom);
            r_data[c] = DATA_W'($urandom);
         end
      end
      if (mstate == 0) begin
         if (MEM_exec) begin
            mstate = 1;
            mcnt   = noans ? 1000 : $urandom_range(1, 4);
         end
         // junk completion strobes: ignored in IDLE and in the issue cycle
         MEM_ready      = noans ? 1'b1 : ($urandom_range(0, 3) != 0);
         MEM_data_ready = 1'($urandom_range(0, 1));
         MEM_data_in    = DATA_W'($urandom);
      end else if (|O_error) begin
         mstate         = 0;
         MEM_ready      = 1'b1;
         MEM_data_ready = 1'b0;
      end else if (mcnt == 1) begin
         d = DATA_W'($urandom);
         if (MEM_write) begin
            MEM_ready      = 1'b1;
            MEM_data_ready = 1'($urandom_range(0, 1));
         end else begin
            MEM_ready      = 1'($urandom_range(0, 1));
            MEM_data_ready = 1'b1;
            MEM_data_in    = d;
         end
         q.push_back(d);
         mstate = 0;
      end else begin
         mcnt--;
         MEM_ready      = 1'b0;
         MEM_data_ready = 1'b0;
      end
      drive();
   endtask

   task automatic do_reset();
      @(negedge I_clk);
      I_reset = 1'b0;
      for (int c = 0; c < NCH; c++) req_on[c] = 1'b0;
      mstate = 0;
      MEM_ready = 1'b0;
      MEM_data_ready = 1'b0;
      drive();
      @(negedge I_clk);
      I_reset = 1'b1;
      MEM_ready = 1'b1;
      MEM_data_ready = 1'b1;
   endtask

   // reference model: round-robin from the pointer over the pending requests
   function automatic int rr_pick(input int p, input logic [NCH-1:0] ex);
      for (int k = 0; k < NCH; k++)
         if (ex[(p + k) % NCH]) return (p + k) % NCH;
      return -1;
   endfunction

   bit                idle, exec_pending, ml_wr;
   int                ptr, cur, wcnt;
   logic [SIZE_W-1:0] ml_size;
   logic [ADDR_W-1:0] ml_addr;
   logic [DATA_W-1:0] ml_data, last_data;

   initial begin : monitor
      logic [NCH-1:0]    exp_acc, exp_drdy, exp_wd, exp_err;
      logic              exp_exec;
      logic [DATA_W-1:0] d;
      int                g;
      idle = 1; exec_pending = 0; ptr = 0; cur = 0; wcnt = 0;
      ml_wr = 0; ml_size = '0; ml_addr = '0; ml_data = '0; last_data = '0;
      forever begin
         @(posedge I_clk);
         #2;
         if (!I_reset) begin
            chk("rst_mem_exec", 64'(MEM_exec), 64'(0));
            chk("rst_mem_fields", 64'({MEM_write, MEM_size, MEM_addr, MEM_data_out}), 64'(0));
            chk("rst_o_data", 64'(O_data), 64'(0));
            chk("rst_pulses", 64'({O_accept, O_data_ready, O_wr_done, O_error}), 64'(0));
            idle = 1; exec_pending = 0; ptr = 0; wcnt = 0;
            ml_wr = 0; ml_size = '0; ml_addr = '0; ml_data = '0; last_data = '0;
            q.delete();
         end else begin
            exp_acc = '0; exp_drdy = '0; exp_wd = '0; exp_err = '0; exp_exec = 1'b0;
            if (idle) begin
               if (MEM_ready && |I_exec) begin
                  g = rr_pick(ptr, I_exec);
                  exp_acc[g] = 1'b1;
                  exp_exec   = 1'b1;
                  ptr        = (g + 1) % NCH;
                  cur        = g;
                  ml_wr = r_wr[g]; ml_size = r_size[g]; ml_addr = r_addr[g]; ml_data = r_data[g];
                  idle = 0; exec_pending = 1; wcnt = 0;
               end
            end else if (exec_pending) begin
               exec_pending = 0;
            end else begin
               wcnt++;
               if (q.size() != 0) begin
                  d = q.pop_front();
                  if (ml_wr) exp_wd[cur] = 1'b1;
                  else begin
                     exp_drdy[cur] = 1'b1;
                     last_data     = d;
                  end
                  idle = 1;
               end
`ifdef MEM_CTRL_TIMEOUT_EN
               else if (wcnt == TIMEOUT) begin
                  exp_err[cur] = 1'b1;
                  idle = 1;
               end
`endif
            end
            chk("accept", 64'(O_accept), 64'(exp_acc));
            chk("mem_exec", 64'(MEM_exec), 64'(exp_exec));
            chk("mem_write", 64'(MEM_write), 64'(ml_wr));
            chk("mem_size", 64'(MEM_size), 64'(ml_size));
            chk("mem_addr", 64'(MEM_addr), 64'(ml_addr));
            chk("mem_data_out", 64'(MEM_data_out), 64'(ml_data));
            chk("data_ready", 64'(O_data_ready), 64'(exp_drdy));
            chk("wr_done", 64'(O_wr_done), 64'(exp_wd));
            chk("error", 64'(O_error), 64'(exp_err));
            chk("o_data", 64'(O_data), 64'(last_data));
            chk("o_ready", 64'(O_ready), 64'({NCH{idle && MEM_ready}}));
         end
      end
   end

   initial begin : stimulus
      bit found;
      I_reset = 1'b0;
      always_req = 0; force_rd = 0; noans = 0; stop_req = 0;
      mstate = 0; mcnt = 0;
      MEM_ready = 1'b0; MEM_data_ready = 1'b0; MEM_data_in = '0;
      for (int c = 0; c < NCH; c++) begin
         req_on[c] = 1'b0; r_wr[c] = 1'b0; r_size[c] = '0; r_addr[c] = '0; r_data[c] = '0;
      end
      drive();
      repeat (3) @(negedge I_clk);
      I_reset = 1'b1;
      repeat (400) begin @(negedge I_clk); step(); end
      // every channel requests continuously: pure round-robin rotation
      always_req = 1;
      repeat (100) begin @(negedge I_clk); step(); end
      always_req = 0;
      // reset while a read is outstanding must drop it silently
      force_rd = 1;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge I_clk); step();
         found = (mstate == 1 && mcnt > 1 && !MEM_write);
      end
      chk("reach_rd_wait", 64'(found), 64'(1));
      force_rd = 0;
      do_reset();
      repeat (100) begin @(negedge I_clk); step(); end
      // memory never answers: watchdog aborts, or controller stays waiting
      noans = 1;
      repeat (60) begin @(negedge I_clk); step(); end
      noans = 0;
      do_reset();
      repeat (200) begin @(negedge I_clk); step(); end
      stop_req = 1;
      repeat (40) begin @(negedge I_clk); step(); end
      chk("drain_queue", 64'(q.size()), 64'(0));
      for (int c = 0; c < NCH; c++) chk("drain_req", 64'(req_on[c]), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
